// File: rtl/spi_flash_reader.sv
// spi_flash_reader
//   Single-lane SPI NOR flash read master (SPI mode 0). A request gives a
//   24-bit start address and a byte count. The block sends the read command,
//   the address and (optionally) dummy clocks, then streams the data bytes
//   out over a valid/ready interface.
//
//   Build option: define SPI_FLASH_FAST_READ_EN to use the 0x0B fast-read
//   command with 8 dummy SCK cycles after the address. When it is undefined,
//   the block uses the plain 0x03 read command with no dummy cycles.
//
// Ports
//   clock, reset            system clock, asynchronous active-high reset
//   req_valid/req_ready     request handshake (ready only in IDLE, with no byte pending)
//   req_addr[23:0]          flash byte address, sampled at accept
//   req_len[7:0]            byte count, sampled at accept (0 = 256)
//   rd_data[7:0]/rd_valid   received byte, held until rd_ready
//   rd_ready                consumer accepts the byte
//   busy, done              transaction in progress / one-cycle end pulse
//   flash_csb, flash_clk    chip select (active low), SCK (idles low)
//   flash_io0, flash_io1    MOSI out, MISO in
module spi_flash_reader #(
  parameter int CLK_DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_len,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        busy,
  output logic        done,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] READ_CMD = 8'h0B;
`else
  localparam logic [7:0] READ_CMD = 8'h03;
`endif

  localparam int DIV_W   = $clog2(CLK_DIV + 1);
  localparam int DESEL_W = $clog2(3 * CLK_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DESEL_W-1:0] CSB_RISE  = DESEL_W'(CLK_DIV);
  localparam logic [DESEL_W-1:0] DESEL_END = DESEL_W'(3 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_PAUSE, ST_DESEL
  } state_t;

  state_t state_reg, state_next;

  logic [DIV_W-1:0]   div_cnt_reg;
  logic [DESEL_W-1:0] desel_cnt_reg;
  logic [4:0]         bit_cnt_reg;
  logic [31:0]        shift_out_reg;
  logic [7:0]         shift_in_reg;
  logic [8:0]         remaining_reg;
  logic               sck_reg;
  logic               cap_pending_reg;
  logic [7:0]         rd_data_reg;
  logic               rd_valid_reg;

  logic accept;
  logic shifting;
  logic tick;
  logic stall;
  logic byte_gate;
  logic rise_evt;
  logic fall_evt;
  logic pause_evt;
  logic phase_end;

  assign accept   = req_valid && req_ready;
  assign shifting = (state_reg == ST_CMD) || (state_reg == ST_ADDR) ||
                    (state_reg == ST_DUMMY) || (state_reg == ST_DATA);
  assign tick     = (div_cnt_reg == DIV_LAST);
  assign stall    = rd_valid_reg && !rd_ready;

  // A data byte may only start (first rising SCK) once the previous byte
  // has left the output register; otherwise it would be overwritten.
  assign byte_gate = (state_reg == ST_DATA) && (bit_cnt_reg == 5'd0) && stall;
  assign rise_evt  = (shifting && tick && !sck_reg && !byte_gate) ||
                     ((state_reg == ST_PAUSE) && !stall);
  assign fall_evt  = shifting && tick && sck_reg;
  assign pause_evt = shifting && tick && !sck_reg && byte_gate;

  always_comb begin
    phase_end = 1'b0;
    case (state_reg)
      ST_CMD, ST_DUMMY, ST_DATA: phase_end = (bit_cnt_reg == 5'd7);
      ST_ADDR:                   phase_end = (bit_cnt_reg == 5'd23);
      default:                   phase_end = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: phase changes happen on the falling SCK edge that
  // completes the last bit of a phase.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_CMD;
      ST_CMD:   if (fall_evt && phase_end) state_next = ST_ADDR;
`ifdef SPI_FLASH_FAST_READ_EN
      ST_ADDR:  if (fall_evt && phase_end) state_next = ST_DUMMY;
      ST_DUMMY: if (fall_evt && phase_end) state_next = ST_DATA;
`else
      ST_ADDR:  if (fall_evt && phase_end) state_next = ST_DATA;
`endif
      ST_DATA: begin
        if (pause_evt) begin
          state_next = ST_PAUSE;
        end else if (fall_evt && phase_end && (remaining_reg == 9'd0)) begin
          state_next = ST_DESEL;
        end
      end
      ST_PAUSE: if (!stall) state_next = ST_DATA;
      ST_DESEL: if (desel_cnt_reg == DESEL_END) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs. DESEL covers both the CS hold after the last SCK fall
  // (first CLK_DIV cycles, CS still low) and the CS-high deselect time.
  always_comb begin
    flash_csb = 1'b1;
    flash_io0 = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    req_ready = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy      = 1'b0;
        req_ready = !rd_valid_reg;
      end
      ST_CMD, ST_ADDR: begin
        flash_csb = 1'b0;
        flash_io0 = shift_out_reg[31];
      end
      ST_DUMMY, ST_DATA, ST_PAUSE: begin
        flash_csb = 1'b0;
      end
      ST_DESEL: begin
        flash_csb = (desel_cnt_reg >= CSB_RISE);
        done      = (desel_cnt_reg == DESEL_END);
      end
      default: begin
        flash_csb = 1'b1;
      end
    endcase
  end

  assign flash_clk = sck_reg;
  assign rd_data   = rd_data_reg;
  assign rd_valid  = rd_valid_reg;

  // Datapath: SCK divider, shift registers, byte counter, output byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt_reg     <= '0;
      desel_cnt_reg   <= '0;
      bit_cnt_reg     <= '0;
      shift_out_reg   <= '0;
      shift_in_reg    <= '0;
      remaining_reg   <= '0;
      sck_reg         <= 1'b0;
      cap_pending_reg <= 1'b0;
      rd_data_reg     <= '0;
      rd_valid_reg    <= 1'b0;
    end else begin
      cap_pending_reg <= 1'b0;
      if (accept) begin
        shift_out_reg <= {READ_CMD, req_addr};
        remaining_reg <= (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
        bit_cnt_reg   <= '0;
        div_cnt_reg   <= '0;
        sck_reg       <= 1'b0;
      end else begin
        if (shifting) begin
          div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
        end else begin
          div_cnt_reg <= '0;
        end
        // MISO is sampled on the same clock edge that raises SCK.
        if (rise_evt) begin
          sck_reg      <= 1'b1;
          shift_in_reg <= {shift_in_reg[6:0], flash_io1};
          if ((state_reg == ST_DATA) && phase_end) begin
            remaining_reg   <= remaining_reg - 1'b1;
            cap_pending_reg <= 1'b1;
          end
        end
        // MOSI advances only as SCK falls, so it is stable while SCK is high.
        if (fall_evt) begin
          sck_reg       <= 1'b0;
          shift_out_reg <= {shift_out_reg[30:0], 1'b0};
          bit_cnt_reg   <= phase_end ? '0 : bit_cnt_reg + 1'b1;
        end
      end

      desel_cnt_reg <= (state_reg == ST_DESEL) ? desel_cnt_reg + 1'b1 : '0;

      // The completed byte is published one cycle after its 8th rising edge.
      if (cap_pending_reg) begin
        rd_data_reg  <= shift_in_reg;
        rd_valid_reg <= 1'b1;
      end else if (rd_valid_reg && rd_ready) begin
        rd_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural SPI NOR model, byte scoreboard,
// and directed transactions (basic read, 256-byte read, backpressure,
// mid-transfer reset, back-to-back requests). Define SPI_FLASH_FAST_READ_EN
// to exercise the fast-read build.
module tb_spi_flash_reader;
  localparam int CLK_DIV = 2;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] EXP_CMD = 8'h0B;
  localparam int HDR_BITS  = 40;
  localparam int FIRST_LAT = 2 + 95 * CLK_DIV;
`else
  localparam logic [7:0] EXP_CMD = 8'h03;
  localparam int HDR_BITS  = 32;
  localparam int FIRST_LAT = 2 + 79 * CLK_DIV;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = '0;
  logic [7:0]  req_len = '0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        flash_csb;
  logic        flash_clk;
  logic        flash_io0;
  logic        flash_io1 = 1'b0;

  spi_flash_reader #(.CLK_DIV(CLK_DIV)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done),
    .flash_csb(flash_csb), .flash_clk(flash_clk),
    .flash_io0(flash_io0), .flash_io1(flash_io1)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- flash memory and SPI model ----------------
  logic [7:0]  mem [0:1023];
  int          rx_cnt = 0;
  logic [31:0] hdr_sr = '0;
  logic [7:0]  cmd_seen = '0;
  logic [23:0] addr_seen = '0;
  int          dummy_ones = 0;
  int          fm_k;
  logic [9:0]  fm_a;

  always @(posedge flash_clk or posedge flash_csb) begin
    if (flash_csb) begin
      rx_cnt = 0;
    end else begin
      if (rx_cnt < 32) hdr_sr = {hdr_sr[30:0], flash_io0};
      else if (rx_cnt < HDR_BITS && flash_io0) dummy_ones = dummy_ones + 1;
      rx_cnt = rx_cnt + 1;
      if (rx_cnt == 32) begin
        cmd_seen  = hdr_sr[31:24];
        addr_seen = hdr_sr[23:0];
      end
    end
  end

  // Mode 0: the flash shifts out the next data bit on each falling SCK.
  always @(negedge flash_clk) begin
    if (!flash_csb && rx_cnt >= HDR_BITS) begin
      fm_k = rx_cnt - HDR_BITS;
      fm_a = addr_seen[9:0] + 10'(fm_k / 8);
      flash_io1 = mem[fm_a][7 - (fm_k % 8)];
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q[$];
  int pop_cnt = 0, done_cnt = 0, acc_cnt = 0;
  int fv_cyc = -1, acc_neg_cyc = 0, done_neg_cyc = 0;
  int csb_run = 0, last_high_run = 0;
  int last_pop_cyc = 0, pop_gap = 0;

  always @(negedge clock) begin
    if (rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        check("data_unexpected", 32'(exp_q.size()), 1);
      end else begin
        check("data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
        $display("byte %0d: %02h at cycle %0d", pop_cnt, rd_data, cyc);
      end
      pop_cnt++;
      pop_gap = cyc - last_pop_cyc;
      last_pop_cyc = cyc;
    end
    if (rd_valid && fv_cyc < 0) fv_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_neg_cyc = cyc;
    end
    if (req_valid && req_ready) begin
      acc_cnt++;
      acc_neg_cyc = cyc;
    end
    if (flash_csb) begin
      csb_run++;
    end else begin
      if (csb_run > 0) last_high_run = csb_run;
      csb_run = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_expected(input logic [23:0] addr, input logic [7:0] len);
    int n;
    n = (len == 8'd0) ? 256 : int'(len);
    for (int i = 0; i < n; i++) exp_q.push_back(mem[10'(int'(addr[9:0]) + i)]);
  endtask

  task automatic start_req(input logic [23:0] addr, input logic [7:0] len, output int acc_edge);
    int guard;
    guard = 0;
    while (!req_ready && guard < 2000) begin
      step();
      guard++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 1);
    push_expected(addr, len);
    req_addr  = addr;
    req_len   = len;
    req_valid = 1'b1;
    fv_cyc    = -1;
    @(posedge clock);
    #1;
    acc_edge  = cyc;
    req_valid = 1'b0;
    $display("request addr %06h len %0d accepted at cycle %0d", addr, len, acc_edge);
    check("csb_low_after_accept", {31'd0, flash_csb}, 0);
    check("io0_cmd_bit7", {31'd0, flash_io0}, {31'd0, EXP_CMD[7]});
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while (busy && guard < 20000) begin
      step();
      guard++;
    end
    check({tag, "_timeout"}, {31'd0, busy}, 0);
    repeat (2) step();
  endtask

  task automatic end_txn(input string tag, input logic [23:0] addr, input int nbytes,
                         input int pops0, input int dones0);
    wait_idle(tag);
    check({tag, "_bytes"}, pop_cnt - pops0, nbytes);
    check({tag, "_done"}, done_cnt - dones0, 1);
    check({tag, "_qempty"}, 32'(exp_q.size()), 0);
    check({tag, "_csb_high"}, {31'd0, flash_csb}, 1);
    check({tag, "_cmd"}, {24'd0, cmd_seen}, {24'd0, EXP_CMD});
    check({tag, "_addr"}, {8'd0, addr_seen}, {8'd0, addr});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int e, p0, d0, a0, guard;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 29 + (i >> 4) + 7);
    mem[0] = 8'h6F; mem[1] = 8'h00; mem[2] = 8'h10; mem[3] = 8'h93;

    repeat (3) step();
    check("rst_csb", {31'd0, flash_csb}, 1);
    check("rst_clk", {31'd0, flash_clk}, 0);
    check("rst_io0", {31'd0, flash_io0}, 0);
    check("rst_rd_valid", {31'd0, rd_valid}, 0);
    check("rst_rd_data", {24'd0, rd_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_req_ready", {31'd0, req_ready}, 1);
    reset = 1'b0;
    repeat (2) step();

    // 1: basic 4-byte read at 0
    p0 = pop_cnt; d0 = done_cnt;
    start_req(24'h000000, 8'd4, e);
    end_txn("t1", 24'h000000, 4, p0, d0);
    check("t1_first_valid", fv_cyc - e, FIRST_LAT - 1);
    check("t1_byte_spacing", pop_gap, 16 * CLK_DIV);
`ifdef SPI_FLASH_FAST_READ_EN
    check("t1_dummy_io0", dummy_ones, 0);
`endif

    // 2: len 0 means 256 bytes
    p0 = pop_cnt; d0 = done_cnt;
    start_req(24'h000100, 8'd0, e);
    end_txn("t2", 24'h000100, 256, p0, d0);
    check("t2_first_valid", fv_cyc - e, FIRST_LAT - 1);

    // 3: backpressure after the first byte
    p0 = pop_cnt; d0 = done_cnt;
    start_req(24'h000040, 8'd4, e);
    guard = 0;
    while (pop_cnt < p0 + 1 && guard < 2000) begin
      step();
      guard++;
    end
    check("t3_first_byte_seen", pop_cnt - p0, 1);
    rd_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (i >= 44) begin
        check("t3_pause_clk", {31'd0, flash_clk}, 0);
        check("t3_pause_csb", {31'd0, flash_csb}, 0);
        check("t3_pause_valid", {31'd0, rd_valid}, 1);
      end
    end
    check("t3_no_extra_pop", pop_cnt - p0, 1);
    rd_ready = 1'b1;
    end_txn("t3", 24'h000040, 4, p0, d0);

    // 4: reset in the address phase, then a fresh request
    start_req(24'h000080, 8'd4, e);
    repeat (60) step();
    check("t4_in_addr_csb", {31'd0, flash_csb}, 0);
    reset = 1'b1;
    #1;
    check("t4_rst_csb", {31'd0, flash_csb}, 1);
    check("t4_rst_clk", {31'd0, flash_clk}, 0);
    check("t4_rst_io0", {31'd0, flash_io0}, 0);
    check("t4_rst_busy", {31'd0, busy}, 0);
    check("t4_rst_req_ready", {31'd0, req_ready}, 1);
    exp_q.delete();
    step();
    reset = 1'b0;
    step();
    p0 = pop_cnt; d0 = done_cnt;
    start_req(24'h000004, 8'd4, e);
    end_txn("t4", 24'h000004, 4, p0, d0);

    // 5: req_valid held high across two transactions
    p0 = pop_cnt; d0 = done_cnt; a0 = acc_cnt;
    push_expected(24'h000010, 8'd2);
    req_addr = 24'h000010; req_len = 8'd2; req_valid = 1'b1;
    guard = 0;
    while (acc_cnt < a0 + 1 && guard < 2000) begin
      step();
      guard++;
    end
    push_expected(24'h000020, 8'd2);
    req_addr = 24'h000020;
    guard = 0;
    while (acc_cnt < a0 + 2 && guard < 2000) begin
      step();
      guard++;
    end
    req_valid = 1'b0;
    check("t5_accepts", acc_cnt - a0, 2);
    check("t5_accept_after_done", acc_neg_cyc, done_neg_cyc + 1);
    wait_idle("t5");
    check("t5_csb_high_gap", last_high_run, 2 * CLK_DIV + 1);
    check("t5_bytes", pop_cnt - p0, 4);
    check("t5_done", done_cnt - d0, 2);
    check("t5_qempty", 32'(exp_q.size()), 0);
    check("t5_addr", {8'd0, addr_seen}, 32'h000020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Synthesizable single-lane SPI flash read master for the user project area. Accepts a start address and byte count, drives a standard serial-NOR read sequence (command, 24-bit address, data) on the flash pins, and returns each data byte over a valid/ready stream. It is the initiator side of the same flash protocol the `spiflash` simulation model answers, and loads RISC-SPM program or data memory from an external flash.

## Interface

- `CLK_DIV`, default 2: system clocks per SCK half-period. Minimum 1.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  read request present.
- `req_ready`  out  1  high only in IDLE; the request is accepted on `req_valid && req_ready`.
- `req_addr`  in  24  flash byte address, sampled at accept.
- `req_len`  in  8  byte count, sampled at accept; 0 means 256.
- `rd_data`  out  8  received byte.
- `rd_valid`  out  1  `rd_data` valid; held until `rd_ready`.
- `rd_ready`  in  1  consumer takes the byte.
- `busy`  out  1  high from accept through end of deselect time.
- `done`  out  1  one-cycle pulse when the transaction ends.
- `flash_csb`  out  1  chip select, active low.
- `flash_clk`  out  1  SCK, SPI mode 0, idles low.
- `flash_io0`  out  1  MOSI.
- `flash_io1`  in  1  MISO.

## Operation

- States: IDLE, CMD (8 bits), ADDR (24 bits), DUMMY (8 bits, macro only), DATA, PAUSE, DESEL.
- IDLE → CMD on accept. Latch address and length. Load the shift register with {0x03, addr}.
- MSB first. `flash_io0` changes only while `flash_clk` is low. `flash_io1` is sampled on the clock edge that drives `flash_clk` high.
- CMD → ADDR → DATA after the 8th and 32nd falling SCK edges respectively.
- DATA: after the 8th rising edge of a byte, the byte is copied to `rd_data` and `rd_valid` is set the next cycle. The remaining byte counter decrements; it is 9 bits wide so 256 can be represented.
- Backpressure: a new data byte's first SCK rising edge is not issued while `rd_valid && !rd_ready`. The controller waits in PAUSE with `flash_clk` low and `flash_csb` low.
- After the last byte's final falling edge, `flash_csb` rises CLK_DIV clocks later. DESEL then lasts 2*CLK_DIV clocks. `done` pulses on the last DESEL cycle, and the controller enters IDLE the next cycle.
- The last byte may still be held in `rd_valid` when `done` fires. A new request cannot be accepted until that byte is consumed.
- `req_valid` is ignored outside IDLE. Address wrap is left to the flash; the controller does not modify the address.
- Reset, at any time including mid-transfer, forces these values immediately: state IDLE, `flash_csb`=1, `flash_clk`=0, `flash_io0`=0, `rd_valid`=0, `rd_data`=0, `busy`=0, `done`=0, `req_ready`=1.

## Timing

- Accept at cycle T. `flash_csb` goes low and `flash_io0`=bit 7 of the command at T+1.
- Overall bit i (0-based) rises at T+1+CLK_DIV+2·CLK_DIV·i and falls CLK_DIV clocks later.
- Without the macro, first `rd_valid` occurs at T+2+79·CLK_DIV (T+160 for CLK_DIV=2).
- With `rd_ready` tied high, bytes follow every 16·CLK_DIV clocks and `rd_valid` is a one-cycle pulse.
- Minimum CSB-high time between transactions is 2·CLK_DIV clocks.

## Configuration

- `SPI_FLASH_FAST_READ_EN` defined:
  - Command is 0x0B.
  - A DUMMY state of 8 SCK cycles with `flash_io0`=0 is inserted after ADDR.
  - First `rd_valid` occurs at T+2+95·CLK_DIV.
- `SPI_FLASH_FAST_READ_EN` undefined: command is 0x03, with no DUMMY state.

## Test plan

- Flash model preloaded with 0x6F,0x00,0x10,0x93 at 0x000000; request addr 0, len 4, `rd_ready`=1, CLK_DIV=2 → MOSI shows 0x03 then 0x000000, and bytes arrive in order with the first at T+160. `done` fires once, and `flash_csb` is high afterwards.
- `req_len`=0 at addr 0x000100 → exactly 256 bytes matching the hex file, then one `done`.
- `rd_ready` low for 50 cycles after byte 1 of a 4-byte read → `flash_clk` stays low with CSB still low, and no byte is lost or duplicated.
- `reset` pulsed during ADDR phase → `flash_csb`=1 and `flash_clk`=0 within the same cycle. A following request at 0x000004 returns correct data.
- `req_valid` held high continuously → the second request is accepted only in the first IDLE cycle after `done`, and CSB stays high for at least 2·CLK_DIV clocks.
- Build with `SPI_FLASH_FAST_READ_EN` → 0x0B plus 8 dummy clocks observed, data correct, and first `rd_valid` at T+192 for CLK_DIV=2.
